// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry, LSB first.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+WIDTH.
// No backpressure: start is ignored while busy; results are held until the next completion.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    count;

    logic             bit_s;
    logic             carry_nxt;
    logic             last_bit;

    // Full-adder cell on the current LSBs, plus the end-of-operand detect.
    always_comb begin
        bit_s     = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        last_bit  = (count == LAST);
    end

    // Next-state logic: IDLE waits for start, ADD runs for exactly WIDTH edges.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start)    state_nxt = ADD;
            ADD:  if (last_bit) state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: operand capture, serial shift, and result publish on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_sh   <= a;
                    b_sh   <= b;
                    sum_sh <= '0;
                    carry  <= 1'b0;
                    count  <= '0;
                end
            end else begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                sum_sh <= {bit_s, sum_sh[WIDTH-1:1]};
                carry  <= carry_nxt;
                // Counter stops at the last index so it never wraps.
                if (!last_bit) begin
                    count <= count + CW'(1);
                end
                if (last_bit) begin
                    sum  <= {bit_s, sum_sh[WIDTH-1:1]};
                    cout <= carry_nxt;
                    done <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == ADD);

endmodule
